// File: rtl/led_status_pkg.sv
// Shared types for the LED status bank: display modes and the shared
// scan/breathe direction.
package led_status_pkg;

    typedef enum logic [1:0] {
        COUNT   = 2'd0,
        SCAN    = 2'd1,
        BREATHE = 2'd2,
        OFF     = 2'd3
    } mode_e;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_e;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a slow asynchronous level such as
// the MMCM lock.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/led_status_bank.sv
// N-channel LED status driver with COUNT / SCAN / BREATHE / OFF display
// modes, gated on the synchronised clock-wizard lock.
module led_status_bank
    import led_status_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int CNT_W    = 64,
    parameter int TAP_LO   = 24,
    parameter int TICK_BIT = 22,
    parameter int PWM_W    = 8
) (
    input  logic                clk_400_000,
    input  logic                RESET,
    input  logic                locked,
    input  logic [1:0]          mode_sel,
    input  logic                mode_stb,
    output logic [NUM_LEDS-1:0] leds,
    output logic                tick
);

    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0] POS_TURN = POS_W'((NUM_LEDS > 1) ? NUM_LEDS - 2 : 0);
    localparam logic [PWM_W-1:0] LEVEL_MAX = '1;

    logic                lk;
    logic [CNT_W-1:0]    counter;
    logic                tick_c;
    mode_e               mode;
    dir_e                dir;
    logic [POS_W-1:0]    pos;
    logic [PWM_W-1:0]    level;

    mode_e               mode_eff;
    logic [POS_W-1:0]    pos_eff;
    logic [PWM_W-1:0]    level_eff;
    logic [NUM_LEDS-1:0] leds_c;

    sync2 u_lock_sync (
        .clk (clk_400_000),
        .rst (RESET),
        .d   (locked),
        .q   (lk)
    );

    assign tick_c = &counter[TICK_BIT-1:0];

    always_ff @(posedge clk_400_000 or posedge RESET) begin
        if (RESET) begin
            counter <= '0;
        end else if (!lk) begin
            counter <= '0;
        end else begin
            counter <= counter + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_400_000 or posedge RESET) begin
        if (RESET) begin
            tick <= 1'b0;
        end else begin
            tick <= lk & tick_c;
        end
    end

    // The mode register keeps its value across lock loss; only the
    // per-mode animation state is cleared.
    always_ff @(posedge clk_400_000 or posedge RESET) begin
        if (RESET) begin
            mode <= COUNT;
        end else if (mode_stb) begin
            mode <= mode_e'(mode_sel);
        end
    end

    always_ff @(posedge clk_400_000 or posedge RESET) begin
        if (RESET) begin
            pos   <= '0;
            dir   <= UP;
            level <= '0;
        end else if (!lk || mode_stb) begin
            pos   <= '0;
            dir   <= UP;
            level <= '0;
        end else if (tick_c) begin
            case (mode)
                SCAN: begin
                    if (NUM_LEDS == 1) begin
                        pos <= '0;
                    end else if (dir == UP) begin
                        if (pos == POS_LAST) begin
                            dir <= DN;
                            pos <= POS_TURN;
                        end else begin
                            pos <= pos + POS_W'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            dir <= UP;
                            pos <= POS_W'(1);
                        end else begin
                            pos <= pos - POS_W'(1);
                        end
                    end
                end
                BREATHE: begin
                    if (dir == UP) begin
                        if (level == LEVEL_MAX) begin
                            dir   <= DN;
                            level <= LEVEL_MAX - PWM_W'(1);
                        end else begin
                            level <= level + PWM_W'(1);
                        end
                    end else begin
                        if (level == '0) begin
                            dir   <= UP;
                            level <= PWM_W'(1);
                        end else begin
                            level <= level - PWM_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A strobe is folded in here so the new mode shows on the very next edge.
    always_comb begin
        mode_eff  = mode_stb ? mode_e'(mode_sel) : mode;
        pos_eff   = mode_stb ? '0 : pos;
        level_eff = mode_stb ? '0 : level;
        leds_c    = '0;
        case (mode_eff)
            COUNT:   leds_c = counter[TAP_LO +: NUM_LEDS];
            SCAN:    leds_c = NUM_LEDS'(1) << pos_eff;
            BREATHE: leds_c = {NUM_LEDS{counter[PWM_W-1:0] < level_eff}};
            default: leds_c = '0;
        endcase
    end

    always_ff @(posedge clk_400_000 or posedge RESET) begin
        if (RESET) begin
            leds <= '0;
        end else begin
            leds <= lk ? leds_c : '0;
        end
    end

endmodule

// File: tb/tb_led_status_bank.sv
// Directed bench for led_status_bank with a small bank (4 LEDs, 16-cycle
// tick, 2-bit PWM) so every mode cycles within a few hundred clocks.
module tb_led_status_bank;

    logic       clk_400_000 = 1'b0;
    logic       RESET;
    logic       locked;
    logic [1:0] mode_sel;
    logic       mode_stb;
    logic [3:0] leds;
    logic       tick;

    int checks   = 0;
    int failures = 0;

    always #5 clk_400_000 = ~clk_400_000;

    led_status_bank #(
        .NUM_LEDS (4),
        .CNT_W    (16),
        .TAP_LO   (4),
        .TICK_BIT (4),
        .PWM_W    (2)
    ) dut (
        .clk_400_000 (clk_400_000),
        .RESET       (RESET),
        .locked      (locked),
        .mode_sel    (mode_sel),
        .mode_stb    (mode_stb),
        .leds        (leds),
        .tick        (tick)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_400_000);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (tick !== 1'b1 && n < 64);
        check(tag, 32'(tick), 32'd1);
    endtask

    task automatic strobe(input logic [1:0] m);
        mode_sel = m;
        mode_stb = 1'b1;
        step(1);
        mode_stb = 1'b0;
    endtask

    logic [3:0] scan_exp [7];
    int         br_exp   [7];

    initial begin
        int n;
        int k;
        int hi;
        logic seen;

        scan_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        br_exp   = '{1, 2, 3, 2, 1, 0, 1};

        RESET    = 1'b1;
        locked   = 1'b0;
        mode_stb = 1'b0;
        mode_sel = 2'd0;
        step(3);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);

        // Run a while in COUNT, then hit reset mid-cycle.
        RESET  = 1'b0;
        locked = 1'b1;
        step(40);
        check("pre_reset_count", 32'(leds), 32'd2);
        #3;
        RESET  = 1'b1;
        locked = 1'b0;
        #1;
        check("async_clear_leds", 32'(leds), 32'd0);
        check("async_clear_tick", 32'(tick), 32'd0);
        step(2);
        RESET = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("unlocked_leds", 32'(leds), 32'd0);
            check("unlocked_tick", 32'(tick), 32'd0);
        end

        locked = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (tick !== 1'b1 && n < 100);
        check("lock_to_tick", n, 32'd18);

        // After edge k (counted from lock), leds shows counter k-3 >> 4.
        for (int i = 1; i <= 272; i++) begin
            step(1);
            k = 18 + i;
            check("count_leds", 32'(leds), 32'(((k - 3) >> 4) & 15));
            check("count_tick", 32'(tick), 32'((k % 16) == 2));
        end

        strobe(2'd1);
        check("scan_start", 32'(leds), 32'd1);
        for (int i = 0; i < 7; i++) begin
            wait_tick("scan_tick");
            step(1);
            check("scan_leds", 32'(leds), 32'(scan_exp[i]));
        end

        // Strobe lands on the tick edge while pos = 2.
        wait_tick("coll_pre_tick");
        step(1);
        check("coll_pos2", 32'(leds), 32'b0100);
        step(14);
        mode_sel = 2'd1;
        mode_stb = 1'b1;
        step(1);
        mode_stb = 1'b0;
        check("coll_tick", 32'(tick), 32'd1);
        check("coll_leds", 32'(leds), 32'b0001);
        step(1);
        check("coll_hold", 32'(leds), 32'b0001);
        wait_tick("coll_tick1");
        step(1);
        check("coll_step1", 32'(leds), 32'b0010);
        wait_tick("coll_tick2");
        step(1);
        check("coll_step2", 32'(leds), 32'b0100);

        strobe(2'd2);
        check("br_start", 32'(leds), 32'd0);
        for (int i = 0; i < 7; i++) begin
            wait_tick("br_tick");
            hi = 0;
            for (int j = 0; j < 4; j++) begin
                step(1);
                check("br_uniform", 32'(leds == 4'h0 || leds == 4'hF), 32'd1);
                hi += int'(leds[0]);
            end
            check("br_duty", hi, br_exp[i]);
        end

        // Level is now 2: lose lock right after the tick.
        wait_tick("br_tick_last");
        locked = 1'b0;
        step(1);
        check("loss_e1", 32'(leds), 32'hF);
        step(1);
        check("loss_e2", 32'(leds), 32'hF);
        step(1);
        check("loss_e3", 32'(leds), 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("loss_leds", 32'(leds), 32'd0);
            check("loss_tick", 32'(tick), 32'd0);
        end

        locked = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
            if (tick !== 1'b1) check("relock_dark", 32'(leds), 32'd0);
        end while (tick !== 1'b1 && n < 100);
        check("relock_tick", n, 32'd18);
        hi = 0;
        for (int j = 0; j < 4; j++) begin
            step(1);
            hi += int'(leds[0]);
        end
        check("relock_duty", hi, 32'd1);

        strobe(2'd3);
        check("off_start", 32'(leds), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("off_leds", 32'(leds), 32'd0);
            if (tick === 1'b1) seen = 1'b1;
        end
        check("off_tick_runs", 32'(seen), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_status_bank.md
# led_status_bank

Parametrised LED status driver for the UltraZed PL carrier. It replaces the fixed 64-bit free-running heartbeat counter with an N-channel bank that has four runtime-selectable display modes: binary count, bouncing scanner, PWM breathe and off. Gating on the clock-wizard `locked` signal is retained. It sits directly behind the `uzed_sysclocks` instance and drives the `PL_LEDx` pins.

## Interface
- `NUM_LEDS`, default 8: LED channel count, 1..32.
- `CNT_W`, default 64: free-running counter width, ≥ `TAP_LO + NUM_LEDS`.
- `TAP_LO`, default 24: lowest counter bit shown in COUNT mode.
- `TICK_BIT`, default 22: a tick fires when `counter[TICK_BIT-1:0]` is all ones; requires `TICK_BIT > PWM_W`.
- `PWM_W`, default 8: PWM resolution in bits.
- `clk_400_000  in  1`: 400 MHz clock, phase 0.
- `RESET  in  1`: reset, asynchronous, active-high.
- `locked  in  1`: MMCM lock. Asynchronous to `clk_400_000`; synchronised internally.
- `mode_sel  in  2`: requested mode. 0 = COUNT, 1 = SCAN, 2 = BREATHE, 3 = OFF.
- `mode_stb  in  1`: one-cycle strobe that loads `mode_sel`.
- `leds  out  NUM_LEDS`: registered LED drive, active-high.
- `tick  out  1`: registered one-cycle pulse on each tick, for downstream pacing.

## Operation
- **Lock synchroniser**
  - 2-flop synchroniser produces `lk`.
  - While `RESET` is high or `lk` = 0: counter, scan position, direction, level and `tick` hold at reset values.
  - `leds` = 0 in that condition, whatever the mode.
- **Counter**
  - `counter` increments by 1 modulo 2^CNT_W each cycle while `lk` = 1.
  - `tick_c` = (`counter[TICK_BIT-1:0]` == all ones).
- **Mode register**
  - Reset value COUNT.
  - On `mode_stb` = 1, `mode` ← `mode_sel` and the mode state clears: `pos` = 0, `dir` = up, `level` = 0.
  - The mode load and clear take priority over a coincident tick update.
- **COUNT**
  - `leds` = `counter[TAP_LO +: NUM_LEDS]`.
- **SCAN**
  - `leds` = one-hot at `pos`.
  - On each tick, `pos` steps in `dir`.
  - At `pos` = NUM_LEDS-1 going up, `dir` flips to down and `pos` goes to NUM_LEDS-2.
  - At `pos` = 0 going down, `dir` flips to up and `pos` goes to 1.
  - With NUM_LEDS = 1, `pos` stays at 0.
- **BREATHE**
  - `level` is PWM_W bits and forms a triangle wave: +1 per tick going up, -1 per tick going down.
  - Direction reverses at 2^PWM_W-1 and at 0. There is no wrap.
  - Every bit of `leds` = (`counter[PWM_W-1:0]` < `level`).
  - `level` = 0 gives fully off. The maximum level gives 255/256 duty.
- **OFF**
  - `leds` = 0.
  - The counter still runs.
- **State FSM** (`mode` ∈ {COUNT, SCAN, BREATHE, OFF}, `dir` ∈ {UP, DN}): transitions happen only on `mode_stb` or on tick as described above.

## Timing
- **Reset values:**
  - `leds` = 0, `tick` = 0, `counter` = 0, `mode` = COUNT.
  - `pos` = 0, `dir` = UP, `level` = 0.
- **Lock latency:**
  - `locked` rising to the first counter increment takes 2 cycles (synchroniser), plus 1 cycle for the `leds` register.
  - Falling `locked` blanks `leds` 3 cycles later.
- **Register latency:** `leds` and `tick` are registered once, so each reflects the cycle-N state at cycle N+1.
- **Mode strobe:** `mode_stb` in cycle N means the new mode is visible on `leds` in cycle N+1.
- **Tick behaviour:**
  - `tick` pulses exactly once per 2^TICK_BIT cycles.
  - The first tick occurs 2^TICK_BIT cycles after lock.
- **Reset mid-operation:** `RESET` clears everything asynchronously in the cycle it asserts. Release takes effect on the next clock edge, subject to `lk`.
- **Counter wrap:** at 2^CNT_W-1 the counter wraps to 0 with no side effects.

## Structure
- Package `led_status_pkg`:
  - `mode_e` enum: COUNT = 2'd0, SCAN = 2'd1, BREATHE = 2'd2, OFF = 2'd3.
  - `dir_e` enum: UP, DN.
- Sub-module `sync2` is the generic 2-flop synchroniser for `locked`. Its async reset is driven by `RESET`.
- All other logic lives in one always block per register group.

## Test plan
All scenarios use NUM_LEDS = 4, TICK_BIT = 4, PWM_W = 2, TAP_LO = 4.
- **Reset and lock gating:** assert `RESET` mid-run, then release with `locked` = 0 for 20 cycles → `leds` = 0, `tick` = 0 throughout. Raise `locked` → first `tick` 2+16 cycles later.
- **COUNT:** lock, hold mode 0 for 256 cycles → `leds` steps 0, 1, ..., 15, one step every 16 cycles, and wraps to 0 at cycle 256.
- **SCAN bounce:** strobe mode 1 → over successive ticks `leds` shows 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- **BREATHE duty:** strobe mode 2, observe 4-cycle PWM windows → `level` rises 0→3, then falls 3→0. The count of high cycles per window equals `level`, all 4 LEDs identical.
- **Strobe/tick collision:** assert `mode_stb` (mode_sel = 1) in the same cycle as `tick_c` while in SCAN at `pos` = 2 → `pos` = 0, `dir` = UP, `leds` = 0001 next cycle.
- **Lock loss mid-run:** in BREATHE at `level` = 2, drop `locked` → `leds` = 0 after 3 cycles. Relock → `level` restarts from 0.
